multicycle_controller: RTL and testbench

// - Multi-cycle FSM controller for the MIPS-lite datapath: addu subu slt jr ori lui lw sw beq j jal addi addiu.
// - Replaces the single-cycle decoder; shares one ALU and one memory port across FETCH/DECODE/EXEC/MEM/WB.
// - Decodes opcode/funct from the instruction register and drives per-state strobes to PC, IR, regfile, ALU and memory.

---
 rtl/multicycle_controller.sv | 278 +++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle FSM controller for the MIPS-lite datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB over one shared ALU and one memory port,
// and decodes per-state strobes from the current state plus the IR opcode/funct.
// Optional build macro MC_MEM_WAIT_EN: memory states stall until mem_ready=1.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               overflow,
  input  logic               positive,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic [1:0]         alu_ctl,
  output logic               alu_src,
  output logic               ext_op,
  output logic [1:0]         reg_dst,
  output logic [1:0]         reg_src,
  output logic               flag,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic [1:0]         npc_sel,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // FETCH is the first enumerator, so it encodes as zero on state_dbg.
  typedef enum logic [STATE_W-1:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    MEM_ADDR,
    MEM_RD,
    MEM_WR,
    WB_R,
    WB_I,
    WB_MEM,
    BRANCH,
    JUMP
  } state_t;

  state_t state;
  state_t next_state;

  logic       mem_done;
  logic       r_legal;
  logic       r_is_jr;
  logic       r_is_slt;
  logic [1:0] r_alu_ctl;
  logic [1:0] i_alu_ctl;
  logic       i_ext_op;

`ifdef MC_MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done = 1'b1;
`endif

  assign state_dbg = state;

  // Classify the R-type funct field and pick its ALU operation (slt subtracts).
  always_comb begin
    r_legal   = 1'b0;
    r_is_jr   = 1'b0;
    r_is_slt  = 1'b0;
    r_alu_ctl = 2'b00;
    case (funct)
      FN_ADDU: r_legal = 1'b1;
      FN_SUBU: begin
        r_legal   = 1'b1;
        r_alu_ctl = 2'b01;
      end
      FN_SLT: begin
        r_legal   = 1'b1;
        r_is_slt  = 1'b1;
        r_alu_ctl = 2'b01;
      end
      FN_JR: begin
        r_legal = 1'b1;
        r_is_jr = 1'b1;
      end
      default: r_legal = 1'b0;
    endcase
  end

  // Pick ALU operation and immediate extension for the I-type arithmetic group.
  always_comb begin
    i_alu_ctl = 2'b00;
    i_ext_op  = 1'b0;
    case (opcode)
      OP_ORI:  i_alu_ctl = 2'b10;
      OP_LUI:  i_alu_ctl = 2'b11;
      OP_ADDI, OP_ADDIU: begin
        i_alu_ctl = 2'b00;
        i_ext_op  = 1'b1;
      end
      default: i_alu_ctl = 2'b00;
    endcase
  end

  // State register; reset always returns the sequence to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode; reset forces every strobe low so nothing is half-written.
  always_comb begin
    next_state = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    alu_ctl    = 2'b00;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    reg_dst    = 2'b00;
    reg_src    = 2'b00;
    flag       = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    npc_sel    = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (reset) begin
      next_state = FETCH;
    end else begin
      case (state)
        FETCH: begin
          mem_read = 1'b1;
          if (mem_done) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            next_state = DECODE;
          end
        end
        DECODE: begin
          case (opcode)
            OP_RTYPE: begin
              if (r_legal) begin
                next_state = EXEC_R;
              end else begin
                illegal    = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
              end
            end
            OP_ORI, OP_LUI, OP_ADDI, OP_ADDIU: next_state = EXEC_I;
            OP_LW, OP_SW:                      next_state = MEM_ADDR;
            OP_BEQ:                            next_state = BRANCH;
            OP_J, OP_JAL:                      next_state = JUMP;
            default: begin
              illegal    = 1'b1;
              instr_done = 1'b1;
              next_state = FETCH;
            end
          endcase
        end
        EXEC_R: begin
          alu_ctl = r_alu_ctl;
          if (r_is_jr) begin
            pc_write   = 1'b1;
            npc_sel    = 2'b11;
            instr_done = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = WB_R;
          end
        end
        WB_R: begin
          alu_ctl    = r_alu_ctl;
          reg_write  = 1'b1;
          reg_dst    = 2'b01;
          if (r_is_slt) begin
            reg_src = 2'b10;
            flag    = ~positive;
          end
          instr_done = 1'b1;
          next_state = FETCH;
        end
        EXEC_I: begin
          alu_src    = 1'b1;
          alu_ctl    = i_alu_ctl;
          ext_op     = i_ext_op;
          next_state = WB_I;
        end
        WB_I: begin
          alu_src   = 1'b1;
          alu_ctl   = i_alu_ctl;
          ext_op    = i_ext_op;
          reg_write = 1'b1;
          if (opcode == OP_ADDI && overflow) begin
            reg_dst = 2'b10;
            reg_src = 2'b10;
            flag    = 1'b1;
          end
          instr_done = 1'b1;
          next_state = FETCH;
        end
        MEM_ADDR: begin
          alu_src    = 1'b1;
          ext_op     = 1'b1;
          next_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          alu_src  = 1'b1;
          ext_op   = 1'b1;
          mem_read = 1'b1;
          if (mem_done) begin
            next_state = WB_MEM;
          end
        end
        WB_MEM: begin
          reg_write  = 1'b1;
          reg_src    = 2'b01;
          instr_done = 1'b1;
          next_state = FETCH;
        end
        MEM_WR: begin
          alu_src   = 1'b1;
          ext_op    = 1'b1;
          mem_write = 1'b1;
          if (mem_done) begin
            instr_done = 1'b1;
            next_state = FETCH;
          end
        end
        BRANCH: begin
          alu_ctl    = 2'b01;
          npc_sel    = 2'b01;
          pc_write   = zero;
          instr_done = 1'b1;
          next_state = FETCH;
        end
        JUMP: begin
          pc_write = 1'b1;
          npc_sel  = 2'b10;
          if (opcode == OP_JAL) begin
            reg_write = 1'b1;
            reg_dst   = 2'b11;
            reg_src   = 2'b11;
          end
          instr_done = 1'b1;
          next_state = FETCH;
        end
        default: next_state = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed cases plus random
// instruction streams compared against a per-instruction effect model.
module tb_multicycle_controller;

`ifdef MC_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  // The controller encodes FETCH as zero on state_dbg.
  localparam logic [3:0] FETCH_CODE = 4'd0;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       positive;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic [1:0] alu_ctl;
  logic       alu_src;
  logic       ext_op;
  logic [1:0] reg_dst;
  logic [1:0] reg_src;
  logic       flag;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] npc_sel;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state_dbg;
  logic [17:0] all_outs;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .overflow(overflow), .positive(positive), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .alu_ctl(alu_ctl), .alu_src(alu_src),
    .ext_op(ext_op), .reg_dst(reg_dst), .reg_src(reg_src), .flag(flag),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .npc_sel(npc_sel), .instr_done(instr_done), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  assign all_outs = {pc_write, ir_write, alu_ctl, alu_src, ext_op, reg_dst, reg_src, flag,
                     reg_write, mem_read, mem_write, npc_sel, instr_done, illegal};

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Visible effects of one whole instruction.
  typedef struct {
    int         lat;
    int         reg_wr;
    logic [1:0] dst;
    logic [1:0] src;
    logic       flg;
    int         mem_rd;
    int         mem_wr;
    int         pc_wr;
    logic [1:0] npc;
    int         ill;
  } expect_t;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Effects per instruction: cycle count, register writes, memory and PC activity.
  function automatic expect_t model(input logic [5:0] op, input logic [5:0] fn,
                                    input logic z, input logic ov, input logic pos);
    expect_t e;
    e.lat = 2; e.reg_wr = 0; e.dst = 2'b00; e.src = 2'b00; e.flg = 1'b0;
    e.mem_rd = 1; e.mem_wr = 0; e.pc_wr = 1; e.npc = 2'b00; e.ill = 1;
    case (op)
      6'h00: begin
        case (fn)
          6'h21, 6'h23: begin e.lat = 4; e.ill = 0; e.reg_wr = 1; e.dst = 2'b01; end
          6'h2A: begin e.lat = 4; e.ill = 0; e.reg_wr = 1; e.dst = 2'b01; e.src = 2'b10; e.flg = !pos; end
          6'h08: begin e.lat = 3; e.ill = 0; e.pc_wr = 2; e.npc = 2'b11; end
          default: e.ill = 1;
        endcase
      end
      6'h0D, 6'h0F, 6'h09: begin e.lat = 4; e.ill = 0; e.reg_wr = 1; end
      6'h08: begin
        e.lat = 4; e.ill = 0; e.reg_wr = 1;
        if (ov) begin e.dst = 2'b10; e.src = 2'b10; e.flg = 1'b1; end
      end
      6'h23: begin e.lat = 5; e.ill = 0; e.reg_wr = 1; e.src = 2'b01; e.mem_rd = 2; end
      6'h2B: begin e.lat = 4; e.ill = 0; e.mem_wr = 1; end
      6'h04: begin e.lat = 3; e.ill = 0; e.pc_wr = 1 + int'(z); e.npc = 2'b01; end
      6'h02: begin e.lat = 3; e.ill = 0; e.pc_wr = 2; e.npc = 2'b10; end
      6'h03: begin
        e.lat = 3; e.ill = 0; e.pc_wr = 2; e.npc = 2'b10;
        e.reg_wr = 1; e.dst = 2'b11; e.src = 2'b11;
      end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  // Run one instruction from FETCH to its instr_done and compare its effects to the model.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z,
                               input logic ov, input logic pos, input logic rdy_random);
    expect_t    e;
    int         cycles = 0;
    int         n_reg_wr = 0, n_mem_rd = 0, n_mem_wr = 0, n_pc_wr = 0, n_ir = 0, n_ill = 0, viol = 0;
    logic [1:0] o_dst = 2'b00, o_src = 2'b00, o_npc = 2'b00;
    logic       o_flg = 1'b0;
    logic       done = 1'b0;
    logic [6:0] fetch_sig = 7'h00;
    string      id;
    e = model(op, fn, z, ov, pos);
    id = $sformatf("op%0h_fn%0h", op, fn);
    zero = z; overflow = ov; positive = pos;
    opcode = 6'($urandom); funct = 6'($urandom);
    mem_ready = rdy_random ? 1'($urandom) : 1'b1;
    while (!done && cycles < 12) begin
      #1;
      if (cycles == 0) fetch_sig = {ir_write, pc_write, mem_read, npc_sel, alu_ctl};
      n_ir     += int'(ir_write);
      n_ill    += int'(illegal);
      n_mem_rd += int'(mem_read);
      n_mem_wr += int'(mem_write);
      viol     += int'(reg_write & mem_write) + int'(ir_write & mem_write);
      if (reg_write) begin
        n_reg_wr++; o_dst = reg_dst; o_src = reg_src; o_flg = flag;
      end
      if (pc_write) begin
        n_pc_wr++;
        if (cycles > 0) o_npc = npc_sel;
      end
      done = instr_done;
      @(posedge clk); #1;
      if (cycles == 0) begin opcode = op; funct = fn; end
      if (rdy_random) mem_ready = 1'($urandom);
      cycles++;
    end
    checkOutput({"fetch_", id}, 32'(fetch_sig), 32'b111_00_00);
    checkOutput({"latency_", id}, cycles, e.lat);
    checkOutput({"ir_write_", id}, n_ir, 1);
    checkOutput({"illegal_", id}, n_ill, e.ill);
    checkOutput({"reg_write_", id}, n_reg_wr, e.reg_wr);
    if (e.reg_wr == 1) begin
      checkOutput({"reg_dst_", id}, 32'(o_dst), 32'(e.dst));
      checkOutput({"reg_src_", id}, 32'(o_src), 32'(e.src));
      if (e.src == 2'b10) checkOutput({"flag_", id}, 32'(o_flg), 32'(e.flg));
    end
    checkOutput({"mem_read_", id}, n_mem_rd, e.mem_rd);
    checkOutput({"mem_write_", id}, n_mem_wr, e.mem_wr);
    checkOutput({"pc_write_", id}, n_pc_wr, e.pc_wr);
    if (e.pc_wr == 2) checkOutput({"npc_sel_", id}, 32'(o_npc), 32'(e.npc));
    checkOutput({"exclusive_", id}, viol, 0);
  endtask

  // Walk lw up to its write-back cycle, then hold reset for three cycles.
  task automatic applyResetMidLw();
    zero = 1'b0; overflow = 1'b0; positive = 1'b1; mem_ready = 1'b1;
    opcode = 6'($urandom); funct = 6'($urandom);
    @(posedge clk); #1;
    opcode = 6'h23;
    repeat (3) begin @(posedge clk); #1; end
    #1;
    checkOutput("pre_reset_reg_write", 32'(reg_write), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("reset_strobes_%0d", i), 32'(all_outs), 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    checkOutput("reset_state_fetch", 32'(state_dbg), 32'(FETCH_CODE));
    checkOutput("fetch_resumes", 32'(ir_write), 32'd1);
  endtask

  // Abort if the run ever stops making progress.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence, optional memory-wait check, then a random instruction stream.
  initial begin
    logic [5:0] tbl_op [15];
    logic [5:0] tbl_fn [15];
    int n_ir;
    tbl_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h08, 6'h09, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h3F};
    tbl_fn = '{6'h21, 6'h23, 6'h2A, 6'h08, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    reset = 1'b1; opcode = 6'h00; funct = 6'h00;
    zero = 1'b0; overflow = 1'b0; positive = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 32'(all_outs), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("reset_state", 32'(state_dbg), 32'(FETCH_CODE));

    applyStimulus(6'h00, 6'h21, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'h04, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'h04, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'h03, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'h08, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(6'h09, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(6'h00, 6'h2A, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(6'h00, 6'h2A, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'h00, 6'h08, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'h02, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'h3F, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    applyResetMidLw();
    applyStimulus(6'h0F, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    if (WAIT_EN) begin
      n_ir = 0;
      for (int i = 0; i < 4; i++) begin
        mem_ready = (i == 3);
        #1;
        checkOutput($sformatf("wait_fetch_state_%0d", i), 32'(state_dbg), 32'(FETCH_CODE));
        n_ir += int'(ir_write);
        @(posedge clk); #1;
        if (i == 3) opcode = 6'h3F;
      end
      checkOutput("wait_ir_write_pulses", n_ir, 1);
      #1;
      checkOutput("wait_illegal_pulse", 32'(illegal), 32'd1);
      @(posedge clk); #1;
      mem_ready = 1'b1;
      #1;
      checkOutput("wait_back_to_fetch", 32'(state_dbg), 32'(FETCH_CODE));
    end

    for (int k = 0; k < 60; k++) begin
      int         idx;
      logic [5:0] fn;
      idx = int'($urandom_range(0, 14));
      fn  = (tbl_op[idx] == 6'h00) ? tbl_fn[idx] : 6'($urandom);
      applyStimulus(tbl_op[idx], fn, 1'($urandom), 1'($urandom), 1'($urandom), !WAIT_EN);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
